pwm_gen: RTL and testbench
==========================

# pwm_gen

Output stage that sits directly downstream of the fuzzy controller top. It converts the controller's 8-bit `duty` command into a single-bit PWM waveform for the power switch. The commanded duty is sampled only at period boundaries. It is slew-limited to at most `STEP` per period, so the switch never sees a step change. When disabled, the block ramps the output down to 0 before going idle.

## Interface
- `DUTY_MAX`, 100, full-scale duty; also the number of ticks per PWM period.
- `PRESCALE`, 10, clocks per tick (≥1); period = `DUTY_MAX*PRESCALE` clocks.
- `STEP`, 5, max change of the applied duty per period (≥1).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  run request, level-sensitive.
- `duty`  in  8  commanded duty from fuzzy controller, 0..255.
- `pwm_out`  out  1  PWM output, registered.
- `duty_applied`  out  8  duty currently in effect, 0..`DUTY_MAX`.
- `period_start`  out  1  one-clock pulse at every period boundary.
- `ramping`  out  1  high while `duty_applied` ≠ current target.

## Operation
- Target: `tgt = min(duty, DUTY_MAX)` in RUN; `tgt = 0` in DRAIN.
- Prescaler `pre` counts 0..`PRESCALE-1`. `tick = (pre == PRESCALE-1)`.
- Phase `ph` counts 0..`DUTY_MAX-1` and advances on `tick`.
- A boundary occurs when `tick && ph == DUTY_MAX-1`.
- At each boundary, `duty_applied` moves toward `tgt`:
  - if `tgt > d`: `d + min(STEP, tgt-d)`
  - if `tgt < d`: `d - min(STEP, d-tgt)`
  - Use 9-bit intermediate arithmetic. The result never under- or overflows.
- Outside boundaries, `duty_applied` is held. Changes on `duty` mid-period have no effect until the next boundary.
- `pwm_out` is registered as `(state != IDLE) && (ph_next < duty_applied_next)`.
  - Each period is high for the first `duty_applied*PRESCALE` clocks, then low.
  - `duty_applied == DUTY_MAX` gives constant high; 0 gives constant low.
- FSM states and transitions:
  - IDLE: counters held at 0, `duty_applied = 0`, `pwm_out = 0`.
    - `en = 1` → RUN. This edge counts as a boundary: `ph = 0`, `pre = 0`, `duty_applied <= min(tgt, STEP)`, `period_start` pulses.
  - RUN, `en = 0` → DRAIN immediately. The current period continues unchanged.
  - DRAIN: `tgt = 0`, same boundary ramp rule.
    - `en = 1` → RUN with no counter restart.
    - At a boundary where the post-update `duty_applied` is 0 → IDLE.
- `ramping = (state != IDLE) && (duty_applied != tgt)`, combinational from registers and `duty`.

## Timing
- Reset values: state = IDLE, `pre = 0`, `ph = 0`, `duty_applied = 0`, `pwm_out = 0`, `period_start = 0`.
- `ramping` reads 0 in reset and IDLE.
- Reset asserted mid-operation forces all of the above asynchronously. No drain ramp occurs.
- Latency: a new `duty` takes effect at the next boundary clock. `pwm_out` reflects it starting that same period. The first high clock is the clock after the boundary edge.
- `period_start` is registered and high for exactly one clock after each boundary edge, including the IDLE→RUN edge. It is not asserted on the DRAIN→IDLE boundary.
- `en` toggling within a period never truncates or restarts the period.
- `duty` > `DUTY_MAX` (e.g. 200) is clamped, not wrapped.

## Structure
- Shared package `pwm_pkg`: state enum (IDLE, RUN, DRAIN) and a `sat_step` function (target, current, step → next).
- The prescaler/phase counter is natural as one sub-module, `pwm_timebase`. It outputs `tick`, `ph` and `boundary`, and takes a `clear` input.
- The FSM, ramp logic and output register stay in `pwm_gen`.

## Test plan
The bench overrides parameters to `DUTY_MAX = 10`, `PRESCALE = 1`, `STEP = 3`, giving a 10-clock period. Clock is 10 ns.
- `duty = 7`, raise `en` → `duty_applied` = 3, 6, 7, 7 in successive periods. `pwm_out` high 3, 6, 7, 7 clocks per period. `ramping` drops in the third period.
- `duty = 200`, `en = 1` → `duty_applied` = 3, 6, 9, 10. `pwm_out` is constant high from the fourth period.
- Steady at 7, drop `en` mid-period → current period completes as 7, then 4, 1, 0. State returns to IDLE, `pwm_out = 0`, and `period_start` stops.
- Steady at 6, change `duty` 6→2 at `ph = 4` → the current period keeps 6 high clocks. The next two periods give 3 and 2.
- Assert `rst` at `ph = 2` while `pwm_out = 1` → `pwm_out`, `duty_applied` and `period_start` are 0 within the same cycle. After release with `en = 1`, the ramp restarts from 3.
- Drain at `duty_applied = 4`, reassert `en` with `duty = 8` → no period restart. The next boundaries give 7, 8.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM output stage.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Move cur toward target by at most step; 9-bit math keeps it wrap-free.
  function automatic logic [7:0] sat_step(input logic [7:0] target,
                                          input logic [7:0] cur,
                                          input logic [7:0] step);
    logic [8:0] t9, c9, s9, diff, res;
    t9   = {1'b0, target};
    c9   = {1'b0, cur};
    s9   = {1'b0, step};
    diff = '0;
    res  = c9;
    if (t9 > c9) begin
      diff = t9 - c9;
      res  = c9 + ((diff > s9) ? s9 : diff);
    end else if (t9 < c9) begin
      diff = c9 - t9;
      res  = c9 - ((diff > s9) ? s9 : diff);
    end
    return res[7:0];
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus phase counter; clear holds both at zero.
module pwm_timebase #(
  parameter int unsigned DUTY_MAX = 100,
  parameter int unsigned PRESCALE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  output logic       tick,
  output logic [7:0] ph,
  output logic       boundary
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre, pre_nxt;
  logic [7:0]    ph_nxt;

  assign tick     = (pre == PW'(PRESCALE - 1));
  assign boundary = tick && (ph == 8'(DUTY_MAX - 1));

  always_comb begin
    pre_nxt = pre;
    ph_nxt  = ph;
    if (clear) begin
      pre_nxt = '0;
      ph_nxt  = '0;
    end else if (tick) begin
      pre_nxt = '0;
      ph_nxt  = boundary ? '0 : ph + 8'd1;
    end else begin
      pre_nxt = pre + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      ph  <= '0;
    end else begin
      pre <= pre_nxt;
      ph  <= ph_nxt;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// Slew-limited PWM output stage: duty sampled at period boundaries,
// ramped by at most STEP per period, drained to zero before idling.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_MAX = 100,
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned STEP     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] duty,
  output logic       pwm_out,
  output logic [7:0] duty_applied,
  output logic       period_start,
  output logic       ramping
);

  localparam logic [7:0] DMAX  = 8'(DUTY_MAX);
  localparam logic [7:0] STEP8 = 8'(STEP);

  state_t     state, state_nxt;
  logic       clear, tick, boundary;
  logic [7:0] ph, ph_nxt;
  logic [7:0] tgt_run, tgt, d_nxt;
  logic       pwm_nxt, ps_nxt;

  assign clear = (state == IDLE);

  pwm_timebase #(
    .DUTY_MAX(DUTY_MAX),
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .tick     (tick),
    .ph       (ph),
    .boundary (boundary)
  );

  assign tgt_run = (duty > DMAX) ? DMAX : duty;
  assign tgt     = (state == DRAIN) ? '0 : tgt_run;
  assign ramping = (state != IDLE) && (duty_applied != tgt);

  // Phase the timebase will hold after this edge, so pwm_out lines up with it.
  always_comb begin
    ph_nxt = ph;
    if (clear || boundary) ph_nxt = '0;
    else if (tick)         ph_nxt = ph + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (en) state_nxt = RUN;
      RUN:   if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en)                             state_nxt = RUN;
        else if (boundary && d_nxt == '0)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    d_nxt = duty_applied;
    if (state == IDLE)  d_nxt = en ? sat_step(tgt_run, '0, STEP8) : '0;
    else if (boundary)  d_nxt = sat_step(tgt, duty_applied, STEP8);
    pwm_nxt = (state_nxt != IDLE) && (ph_nxt < d_nxt);
    // The IDLE->RUN edge starts a period; the DRAIN->IDLE edge does not.
    ps_nxt  = (state_nxt != IDLE) && (clear || boundary);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_applied <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      duty_applied <= d_nxt;
      pwm_out      <= pwm_nxt;
      period_start <= ps_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen with DUTY_MAX=10, PRESCALE=1, STEP=3.
module tb_pwm_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] duty;
  logic       pwm_out;
  logic [7:0] duty_applied;
  logic       period_start;
  logic       ramping;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    int en;
    int duty;
    int d;
    int high;
    int ramp;
  } vec_t;

  vec_t tbl[20];

  pwm_gen #(
    .DUTY_MAX(10),
    .PRESCALE(1),
    .STEP(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .duty_applied (duty_applied),
    .period_start (period_start),
    .ramping      (ramping)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs are applied on the last negedge of the previous period; the next
  // negedge is the first clock of the period under test.
  task automatic run_row(input int idx);
    vec_t v;
    int   highs;
    int   held;
    v     = tbl[idx];
    en    = (v.en != 0);
    duty  = 8'(v.duty);
    highs = 0;
    held  = 1;
    @(negedge clk);
    chk($sformatf("row%0d period_start", idx), int'(period_start), 1);
    chk($sformatf("row%0d ramping", idx), int'(ramping), v.ramp);
    chk($sformatf("row%0d duty_applied", idx), int'(duty_applied), v.d);
    for (int s = 0; s < 10; s++) begin
      if (s > 0) @(negedge clk);
      if (pwm_out) highs++;
      if (int'(duty_applied) != v.d) held = 0;
      if (s > 0 && period_start) held = 0;
    end
    chk($sformatf("row%0d held", idx), held, 1);
    chk($sformatf("row%0d high_clocks", idx), highs, v.high);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_row(i);
  endtask

  initial begin
    int highs;
    int bad;

    //            en duty  d high ramp
    tbl[0]  = '{1,   7,  3,  3, 1};
    tbl[1]  = '{1,   7,  6,  6, 1};
    tbl[2]  = '{1,   7,  7,  7, 0};
    tbl[3]  = '{1,   7,  7,  7, 0};
    tbl[4]  = '{0,   7,  4,  4, 1};
    tbl[5]  = '{0,   7,  1,  1, 1};
    tbl[6]  = '{1, 200,  3,  3, 1};
    tbl[7]  = '{1, 200,  6,  6, 1};
    tbl[8]  = '{1, 200,  9,  9, 1};
    tbl[9]  = '{1, 200, 10, 10, 0};
    tbl[10] = '{1, 200, 10, 10, 0};
    tbl[11] = '{1,   6,  7,  7, 1};
    tbl[12] = '{1,   6,  6,  6, 0};
    tbl[13] = '{1,   2,  3,  3, 1};
    tbl[14] = '{1,   2,  2,  2, 0};
    tbl[15] = '{1,   9,  3,  3, 1};
    tbl[16] = '{1,   9,  6,  6, 1};
    tbl[17] = '{1,   4,  4,  4, 0};
    tbl[18] = '{1,   8,  7,  7, 1};
    tbl[19] = '{1,   8,  8,  8, 0};

    rst  = 1'b1;
    en   = 1'b0;
    duty = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset pwm_out", int'(pwm_out), 0);
    chk("reset duty_applied", int'(duty_applied), 0);
    chk("reset period_start", int'(period_start), 0);
    chk("reset ramping", int'(ramping), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle period_start", int'(period_start), 0);

    // Ramp up to 7.
    run_rows(0, 3);

    // Drop en mid-period at 7: period finishes at 7, then 4, 1, 0 and idle.
    highs = 0;
    @(negedge clk);
    chk("drain start period_start", int'(period_start), 1);
    for (int s = 0; s < 10; s++) begin
      if (s > 0) @(negedge clk);
      if (pwm_out) highs++;
      if (s == 4) en = 1'b0;
      if (s == 5) chk("drain ramping", int'(ramping), 1);
    end
    chk("drain last period high_clocks", highs, 7);
    chk("drain last period duty_applied", int'(duty_applied), 7);
    run_rows(4, 5);
    @(negedge clk);
    chk("idle after drain duty_applied", int'(duty_applied), 0);
    chk("idle after drain pwm_out", int'(pwm_out), 0);
    chk("idle after drain period_start", int'(period_start), 0);
    chk("idle after drain ramping", int'(ramping), 0);
    bad = 0;
    for (int s = 0; s < 15; s++) begin
      @(negedge clk);
      if (period_start || pwm_out || duty_applied != 8'd0) bad++;
    end
    chk("idle stays quiet", bad, 0);

    // Over-range duty clamps to full scale, then back down to 6.
    run_rows(6, 12);

    // Steady at 6, change duty to 2 at ph=4: this period stays 6.
    highs = 0;
    @(negedge clk);
    chk("midchange period_start", int'(period_start), 1);
    for (int s = 0; s < 10; s++) begin
      if (s > 0) @(negedge clk);
      if (pwm_out) highs++;
      if (s == 4) duty = 8'd2;
      if (s == 5) chk("midchange ramping", int'(ramping), 1);
    end
    chk("midchange high_clocks", highs, 6);
    chk("midchange duty_applied", int'(duty_applied), 6);
    run_rows(13, 14);

    // Asynchronous reset at ph=2 while pwm_out is high.
    duty = 8'd9;
    @(negedge clk);
    chk("prereset duty_applied", int'(duty_applied), 5);
    @(negedge clk);
    @(negedge clk);
    chk("prereset pwm_out", int'(pwm_out), 1);
    rst = 1'b1;
    #1;
    chk("async rst pwm_out", int'(pwm_out), 0);
    chk("async rst duty_applied", int'(duty_applied), 0);
    chk("async rst period_start", int'(period_start), 0);
    chk("async rst ramping", int'(ramping), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_rows(15, 17);

    // Drain at 4, re-enable with duty 8 mid-period: no restart.
    highs = 0;
    bad   = 0;
    @(negedge clk);
    chk("reen period_start", int'(period_start), 1);
    for (int s = 0; s < 10; s++) begin
      if (s > 0) @(negedge clk);
      if (pwm_out) highs++;
      if (s > 0 && period_start) bad++;
      if (s == 2) en = 1'b0;
      if (s == 4) chk("reen drain ramping", int'(ramping), 1);
      if (s == 6) begin
        en   = 1'b1;
        duty = 8'd8;
      end
    end
    chk("reen high_clocks", highs, 4);
    chk("reen no restart", bad, 0);
    run_rows(18, 19);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary by time limit, expected completion");
    $fatal(1);
  end

endmodule
